// File: rtl/power_state_monitor_if.sv
// Bus between the main FSM, the power/working monitor and the display drivers.
// The FSM side drives state and clean_done; the monitor drives every flag/LED.
interface power_state_monitor_if #(
  parameter int STATE_W    = 3,
  parameter int NUM_LEVELS = 3,
  parameter int TIME_W     = 20
);
  logic [STATE_W-1:0]    state;
  logic                  clean_done;
  logic                  is_power_on;
  logic                  is_working;
  logic [NUM_LEVELS-1:0] level_led;
  logic                  power_led;
  logic [TIME_W-1:0]     work_time_s;
  logic                  clean_reminder;
  logic                  state_err;

  modport master (
    output state, clean_done,
    input  is_power_on, is_working, level_led, power_led,
    input  work_time_s, clean_reminder, state_err
  );

  modport slave (
    input  state, clean_done,
    output is_power_on, is_working, level_led, power_led,
    output work_time_s, clean_reminder, state_err
  );
endinterface

// File: rtl/power_state_monitor.sv
// Registered power/working decode for the range-hood controller: state flags,
// one-hot fan-level LEDs, blinking power LED, working-time accumulation and
// the self-clean reminder.
module power_state_monitor #(
  parameter int STATE_W        = 3,
  parameter int OFF_CODE       = 0,
  parameter int STANDBY_CODE   = 1,
  parameter int SELECT_CODE    = 2,
  parameter int LEVEL_BASE     = 3,
  parameter int NUM_LEVELS     = 3,
  parameter int CLEAN_CODE     = 6,
  parameter int TICK_DIV       = 100_000_000,
  parameter int TIME_W         = 20,
  parameter int CLEAN_THRESH_S = 36000,
  parameter int BLINK_SLOW     = 50_000_000,
  parameter int BLINK_FAST     = 12_500_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  power_state_monitor_if.slave bus
);

  localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BLINK_MAX = (BLINK_SLOW > BLINK_FAST) ? BLINK_SLOW : BLINK_FAST;
  localparam int BLK_W     = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [BLK_W-1:0]  SLOW_LAST = BLK_W'(BLINK_SLOW - 1);
  localparam logic [BLK_W-1:0]  FAST_LAST = BLK_W'(BLINK_FAST - 1);
  localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};
  // A threshold wider than the counter can never be reached.
  localparam bit                THRESH_OK = ($clog2(CLEAN_THRESH_S + 1) <= TIME_W);
  localparam logic [TIME_W-1:0] THRESH    = TIME_W'(CLEAN_THRESH_S);

  // Registered state
  logic [STATE_W-1:0]    state_q;
  logic [BLK_W-1:0]      slow_cnt;
  logic [BLK_W-1:0]      fast_cnt;
  logic                  slow_ph;
  logic                  fast_ph;
  logic [PRE_W-1:0]      presc;
  logic                  power_on;
  logic                  working;
  logic [NUM_LEVELS-1:0] level;
  logic                  led;
  logic [TIME_W-1:0]     work_time;
  logic                  reminder;
  logic                  err;

  // Combinational next values
  logic [31:0]           state_ext;
  logic                  is_off;
  logic                  is_level;
  logic                  is_slow;
  logic                  is_clean;
  logic                  is_defined;
  logic [NUM_LEVELS-1:0] level_dec;
  logic                  state_changed;
  logic [BLK_W-1:0]      slow_cnt_n;
  logic [BLK_W-1:0]      fast_cnt_n;
  logic                  slow_ph_n;
  logic                  fast_ph_n;
  logic                  led_n;
  logic [PRE_W-1:0]      presc_n;
  logic [TIME_W-1:0]     work_time_n;
  logic                  reminder_n;

  // Classify the incoming state code and build the one-hot level vector.
  always_comb begin
    state_ext  = 32'(bus.state);
    is_off     = (state_ext == 32'(OFF_CODE));
    is_level   = (state_ext >= 32'(LEVEL_BASE)) &&
                 (state_ext < 32'(LEVEL_BASE + NUM_LEVELS));
    is_slow    = (state_ext == 32'(STANDBY_CODE)) || (state_ext == 32'(SELECT_CODE));
    is_clean   = (state_ext == 32'(CLEAN_CODE));
    is_defined = is_off || is_level || is_slow || is_clean;
    level_dec  = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      level_dec[i] = (state_ext == 32'(LEVEL_BASE + i));
    end
  end

  // Blink phases: restart with both phases on whenever the state code moves.
  always_comb begin
    state_changed = (bus.state != state_q);
    slow_cnt_n    = slow_cnt;
    fast_cnt_n    = fast_cnt;
    slow_ph_n     = slow_ph;
    fast_ph_n     = fast_ph;
    if (state_changed) begin
      slow_cnt_n = '0;
      fast_cnt_n = '0;
      slow_ph_n  = 1'b1;
      fast_ph_n  = 1'b1;
    end else begin
      if (slow_cnt == SLOW_LAST) begin
        slow_cnt_n = '0;
        slow_ph_n  = ~slow_ph;
      end else begin
        slow_cnt_n = slow_cnt + 1'b1;
      end
      if (fast_cnt == FAST_LAST) begin
        fast_cnt_n = '0;
        fast_ph_n  = ~fast_ph;
      end else begin
        fast_cnt_n = fast_cnt + 1'b1;
      end
    end
  end

  // Power LED pattern selected from the new state, using next-cycle phases.
  always_comb begin
    if (is_off) begin
      led_n = 1'b0;
    end else if (is_level) begin
      led_n = 1'b1;
    end else if (is_slow) begin
      led_n = slow_ph_n;
    end else begin
      led_n = fast_ph_n;
    end
  end

  // Seconds prescaler, saturating time counter and reminder; clean_done wins.
  always_comb begin
    presc_n     = presc;
    work_time_n = work_time;
    reminder_n  = reminder;
    if (bus.clean_done) begin
      presc_n     = '0;
      work_time_n = '0;
      reminder_n  = 1'b0;
    end else begin
      reminder_n = reminder | (THRESH_OK && (work_time >= THRESH));
      if (working) begin
        if (presc == PRE_LAST) begin
          presc_n = '0;
          if (work_time != TIME_MAX) begin
            work_time_n = work_time + 1'b1;
          end else begin
            work_time_n = work_time;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
      end else begin
        presc_n = presc;
      end
    end
  end

  // Register every output and counter; reset clears all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      slow_cnt  <= '0;
      fast_cnt  <= '0;
      slow_ph   <= 1'b0;
      fast_ph   <= 1'b0;
      presc     <= '0;
      power_on  <= 1'b0;
      working   <= 1'b0;
      level     <= '0;
      led       <= 1'b0;
      work_time <= '0;
      reminder  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= bus.state;
      slow_cnt  <= slow_cnt_n;
      fast_cnt  <= fast_cnt_n;
      slow_ph   <= slow_ph_n;
      fast_ph   <= fast_ph_n;
      presc     <= presc_n;
      power_on  <= ~is_off;
      working   <= is_level;
      level     <= level_dec;
      led       <= led_n;
      work_time <= work_time_n;
      reminder  <= reminder_n;
      err       <= ~is_defined;
    end
  end

  assign bus.is_power_on    = power_on;
  assign bus.is_working     = working;
  assign bus.level_led      = level;
  assign bus.power_led      = led;
  assign bus.work_time_s    = work_time;
  assign bus.clean_reminder = reminder;
  assign bus.state_err      = err;

endmodule

// File: tb/tb_power_state_monitor.sv
// Bench for power_state_monitor: directed scenarios with hand-computed
// expectations plus randomized state/clean_done traffic, all compared every
// cycle against a behavioural model built from working-cycle and
// cycles-since-change counts.
module tb_power_state_monitor;

  localparam int TICK    = 4;
  localparam int THRESH  = 3;
  localparam int SLOW    = 8;
  localparam int FAST    = 2;
  localparam int TMAX    = 15;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  power_state_monitor_if #(.STATE_W(3), .NUM_LEVELS(3), .TIME_W(4)) bus ();

  power_state_monitor #(
    .STATE_W(3), .OFF_CODE(0), .STANDBY_CODE(1), .SELECT_CODE(2),
    .LEVEL_BASE(3), .NUM_LEVELS(3), .CLEAN_CODE(6),
    .TICK_DIV(TICK), .TIME_W(4), .CLEAN_THRESH_S(THRESH),
    .BLINK_SLOW(SLOW), .BLINK_FAST(FAST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: expected outputs after the most recent clock edge.
  int   m_prev;      // state seen at the previous edge
  int   m_n;         // cycles since the state last changed
  int   m_cycles;    // working cycles since the last clear
  bit   m_pwr, m_work, m_led, m_rem, m_err;
  int   m_level;

  function automatic int exp_time();
    return ((m_cycles / TICK) > TMAX) ? TMAX : (m_cycles / TICK);
  endfunction

  task automatic model_reset();
    m_prev = 0; m_n = 0; m_cycles = 0;
    m_pwr = 0; m_work = 0; m_led = 0; m_rem = 0; m_err = 0; m_level = 0;
  endtask

  task automatic model_edge(input int st, input bit cd);
    int cur;
    cur = exp_time();
    m_rem = cd ? 1'b0 : (m_rem || (cur >= THRESH));
    if (cd) m_cycles = 0;
    else if (m_work) m_cycles = m_cycles + 1;
    m_n    = (st != m_prev) ? 0 : m_n + 1;
    m_prev = st;
    m_pwr  = (st != 0);
    m_work = (st >= 3 && st <= 5);
    m_level = m_work ? (1 << (st - 3)) : 0;
    m_err  = (st == 7);
    if (st == 0)                  m_led = 1'b0;
    else if (m_work)              m_led = 1'b1;
    else if (st == 1 || st == 2)  m_led = ((m_n / SLOW) % 2) == 0;
    else                          m_led = ((m_n / FAST) % 2) == 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("is_power_on",    int'(bus.is_power_on),    int'(m_pwr));
      chk("is_working",     int'(bus.is_working),     int'(m_work));
      chk("level_led",      int'(bus.level_led),      m_level);
      chk("power_led",      int'(bus.power_led),      int'(m_led));
      chk("work_time_s",    int'(bus.work_time_s),    exp_time());
      chk("clean_reminder", int'(bus.clean_reminder), int'(m_rem));
      chk("state_err",      int'(bus.state_err),      int'(m_err));
    end
  end

  // Apply inputs for one clock edge, advance the model, settle past negedge.
  task automatic step(input int st, input bit cd);
    bus.state      = 3'(st);
    bus.clean_done = cd;
    model_edge(st, cd);
    @(negedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_power_on",  int'(bus.is_power_on),    0);
    chk("rst_working",   int'(bus.is_working),     0);
    chk("rst_level",     int'(bus.level_led),      0);
    chk("rst_led",       int'(bus.power_led),      0);
    chk("rst_time",      int'(bus.work_time_s),    0);
    chk("rst_reminder",  int'(bus.clean_reminder), 0);
    chk("rst_err",       int'(bus.state_err),      0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int st;
    int hold;
    rst_n = 1'b1;
    bus.state = 3'd0;
    bus.clean_done = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Outputs stay 0 with state OFF after release.
    for (int i = 0; i < 3; i++) step(0, 1'b0);
    chk("idle_power_on", int'(bus.is_power_on), 0);
    chk("idle_led",      int'(bus.power_led),   0);

    // Decode sweep: one code per three cycles, checked one cycle after applying.
    for (int s = 0; s < 8; s++) begin
      step(s, 1'b0);
      case (s)
        0: chk("sweep0_power_on", int'(bus.is_power_on), 0);
        3: begin
          chk("sweep3_level", int'(bus.level_led), 1);
          chk("sweep3_work",  int'(bus.is_working), 1);
        end
        4: chk("sweep4_level", int'(bus.level_led), 2);
        5: chk("sweep5_level", int'(bus.level_led), 4);
        6: begin
          chk("sweep6_work",  int'(bus.is_working), 0);
          chk("sweep6_level", int'(bus.level_led), 0);
        end
        7: begin
          chk("sweep7_err",      int'(bus.state_err), 1);
          chk("sweep7_power_on", int'(bus.is_power_on), 1);
        end
        default: ;
      endcase
      step(s, 1'b0);
      step(s, 1'b0);
    end

    // Clear counters, then slow blink: 8 on, 8 off, repeating.
    step(0, 1'b1);
    for (int k = 0; k < 32; k++) begin
      step(1, 1'b0);
      chk("slow_blink", int'(bus.power_led), ((k < 8) || (k >= 16 && k < 24)) ? 1 : 0);
    end
    // Clean code: fast blink 1,1,0,0,...
    for (int k = 0; k < 8; k++) begin
      step(6, 1'b0);
      chk("fast_blink", int'(bus.power_led), ((k % 4) < 2) ? 1 : 0);
    end
    // Fan level: steady on.
    for (int k = 0; k < 4; k++) begin
      step(4, 1'b0);
      chk("level_led_on", int'(bus.power_led), 1);
    end

    // Time accumulation across a pause: 12 working cycles = 3 seconds.
    step(0, 1'b1);
    for (int k = 0; k < 6; k++)  step(3, 1'b0);
    for (int k = 0; k < 10; k++) step(1, 1'b0);
    for (int k = 0; k < 6; k++)  step(3, 1'b0);
    step(0, 1'b0);
    chk("time_3", int'(bus.work_time_s), 3);
    chk("rem_not_yet", int'(bus.clean_reminder), 0);
    step(0, 1'b0);
    chk("rem_set", int'(bus.clean_reminder), 1);
    step(0, 1'b0);
    step(0, 1'b0);
    chk("rem_kept_off", int'(bus.clean_reminder), 1);

    // clean_done coincident with a prescaler wrap.
    for (int k = 0; k < 4; k++) step(3, 1'b0);
    chk("pre_clean_time", int'(bus.work_time_s), 3);
    step(3, 1'b1);
    chk("clean_time", int'(bus.work_time_s), 0);
    chk("clean_rem",  int'(bus.clean_reminder), 0);
    for (int k = 0; k < 3; k++) step(3, 1'b0);
    chk("presc_cleared", int'(bus.work_time_s), 0);
    step(3, 1'b0);
    chk("first_sec_after_clean", int'(bus.work_time_s), 1);

    // Saturation.
    for (int k = 0; k < 80; k++) step(3, 1'b0);
    chk("sat_time", int'(bus.work_time_s), 15);
    chk("sat_rem",  int'(bus.clean_reminder), 1);

    // Asynchronous reset mid-run.
    async_reset();
    for (int k = 0; k < 3; k++) step(0, 1'b0);
    chk("post_rst_time", int'(bus.work_time_s), 0);
    chk("post_rst_pwr",  int'(bus.is_power_on), 0);

    // Randomized traffic.
    for (int r = 0; r < 120; r++) begin
      st   = int'($urandom_range(0, 7));
      hold = int'($urandom_range(1, 6));
      for (int h = 0; h < hold; h++) begin
        step(st, ($urandom_range(0, 11) == 0));
      end
      if (r == 60) async_reset();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/power_state_monitor.md
Name: power_state_monitor

Overview:
- Parametrised, registered successor to the combinational power/working decode for the range-hood controller.
- Decodes the main FSM state into power and working flags, a one-hot fan-level LED vector and a power LED with blink patterns.
- Accumulates working time in seconds and raises a self-clean reminder when a threshold is reached.
- Sits between the main FSM and the LED/7-seg display drivers.

Parameters:
- STATE_W, 3, width of the state input
- OFF_CODE, 0, power-off state code
- STANDBY_CODE, 1, standby state code
- SELECT_CODE, 2, mode-select state code
- LEVEL_BASE, 3, code of the first fan level; levels occupy LEVEL_BASE..LEVEL_BASE+NUM_LEVELS-1
- NUM_LEVELS, 3, number of fan levels (1..8)
- CLEAN_CODE, 6, self-clean state code
- TICK_DIV, 100_000_000, clock cycles per second
- TIME_W, 20, width of the working-time counter
- CLEAN_THRESH_S, 36000, working seconds before the reminder is raised
- BLINK_SLOW, 50_000_000, half-period in cycles of the slow blink
- BLINK_FAST, 12_500_000, half-period in cycles of the fast blink

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- state  in  STATE_W  current main FSM state
- clean_done  in  1  one-cycle pulse from the FSM when self-clean completes
- is_power_on  out  1  high when state != OFF_CODE
- is_working  out  1  high when state is a fan-level code
- level_led  out  NUM_LEVELS  one-hot; bit i high when state == LEVEL_BASE+i
- power_led  out  1  power indicator LED
- work_time_s  out  TIME_W  accumulated working seconds
- clean_reminder  out  1  high when self-clean is due
- state_err  out  1  high when state is not a defined code

Behaviour:
- Reset: one clock, asynchronous active-low reset. While rst_n=0, every output and internal counter is 0, including the blink phases.
- Latency: all outputs are registered. A state change appears on is_power_on, is_working, level_led and state_err exactly 1 cycle later.
- Decode: is_working = (state >= LEVEL_BASE) && (state < LEVEL_BASE+NUM_LEVELS).
- Undefined codes (any value not OFF, STANDBY, SELECT, a level, or CLEAN):
  - state_err=1, is_power_on=1, is_working=0, level_led=0, power_led follows the fast blink.
- power_led:
  - OFF: 0
  - STANDBY or SELECT: slow blink
  - level: steady 1
  - CLEAN or undefined: fast blink
- Blink generator:
  - Free-running counter; each phase toggles every BLINK_SLOW or BLINK_FAST cycles.
  - On any cycle where state differs from its registered copy, the counter restarts and both phases are set to 1, so the LED is on in the first cycle of the new pattern.
- Seconds prescaler: counts 0..TICK_DIV-1 only while the registered is_working is 1.
  - When not working it holds its value, so partial seconds are kept across pauses and power-off.
  - On wrap to 0, work_time_s increments by 1 and saturates at 2^TIME_W-1. There is no wrap-around.
- clean_reminder: set on the cycle after work_time_s >= CLEAN_THRESH_S. It stays set while not working and through OFF.
- clean_done=1 has priority over a coincident second tick. On the next cycle:
  - work_time_s=0
  - prescaler=0
  - clean_reminder=0
- clean_done while clean_reminder=0 still clears the counters.
- Reset mid-operation clears all counters immediately. Accumulated time does not survive reset.
- Width rules: prescaler width = clog2(TICK_DIV). Blink counter width = clog2(max(BLINK_SLOW, BLINK_FAST)). Comparisons are unsigned.

Test Plan:
Bench parameters: TICK_DIV=4, CLEAN_THRESH_S=3, BLINK_SLOW=8, BLINK_FAST=2, TIME_W=4.
- Reset: rst_n=0 mid-run, asynchronously and without a clock edge -> all outputs 0 immediately; after release with state=0, outputs stay 0.
- Decode sweep: state 0..7, one per 3 cycles -> 1 cycle later:
  - state=0: is_power_on=0
  - state=3: level_led=001, is_working=1
  - state=4: level_led=010
  - state=5: level_led=100
  - state=6: is_working=0, level_led=000
  - state=7: state_err=1, is_power_on=1
- Blink: state=1 held 32 cycles -> power_led=1 for 8 cycles, 0 for 8, repeating. Switch to 6 -> power_led=1 next cycle, then toggles every 2 cycles. Switch to 4 -> power_led steady 1.
- Time accumulation: state=3 for 6 cycles, state=1 for 10, state=3 for 6 -> work_time_s=3 (partial second preserved across the pause). clean_reminder=1 on the following cycle, and still 1 after state=0.
- Clean clear: with work_time_s=3, pulse clean_done on the same cycle as a prescaler wrap -> next cycle work_time_s=0, clean_reminder=0, prescaler=0.
- Saturation: state=3 for 80 cycles -> work_time_s saturates at 15 and stays; clean_reminder=1.
